// File: rtl/text_video_pkg.sv
// Shared geometry defaults and helpers for the text-mode video path.
// DEF_*   : default grid, glyph and colour geometry
// HADDR_W : raster coordinate width
// font_index : glyph-row index into the font ROM for a character code and glyph row
package text_video_pkg;

  localparam int unsigned DEF_COLS       = 70;
  localparam int unsigned DEF_ROWS       = 30;
  localparam int unsigned DEF_GLYPH_W    = 9;
  localparam int unsigned DEF_GLYPH_H    = 16;
  localparam int unsigned DEF_COLOR_W    = 12;
  localparam int unsigned DEF_BLINK_LOG2 = 4;
  localparam int unsigned HADDR_W        = 10;

  // Glyphs are stored as GLYPH_H consecutive rows per character code.
  function automatic int unsigned font_index(input logic [7:0] code, input int unsigned yin,
                                             input int unsigned glyph_h);
    return 32'(code) * glyph_h + yin;
  endfunction

endpackage

// File: rtl/text_cell_counter.sv
// Tracks the character cell under the raster position.
// clk, clrn          : pixel clock, async active-low reset
// valid_in           : h_addr/v_addr describe an active pixel
// h_addr, v_addr     : raster position
// col_next, row_next, yin_next : cell coordinates of the pixel being accepted this cycle
// xin, yin           : registered in-glyph coordinates of the last accepted pixel
module text_cell_counter
  import text_video_pkg::*;
#(
  parameter int unsigned ROWS    = DEF_ROWS,
  parameter int unsigned GLYPH_W = DEF_GLYPH_W,
  parameter int unsigned GLYPH_H = DEF_GLYPH_H,
  parameter int unsigned ROW_W   = $clog2(ROWS),
  parameter int unsigned XIN_W   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1,
  parameter int unsigned YIN_W   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               valid_in,
  input  logic [HADDR_W-1:0] h_addr,
  input  logic [HADDR_W-1:0] v_addr,
  output logic [HADDR_W-1:0] col_next,
  output logic [ROW_W-1:0]   row_next,
  output logic [YIN_W-1:0]   yin_next,
  output logic [XIN_W-1:0]   xin,
  output logic [YIN_W-1:0]   yin
);

  logic [HADDR_W-1:0] col_q, col_d;
  logic [XIN_W-1:0]   xin_q, xin_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [YIN_W-1:0]   yin_q, yin_d;
  logic [HADDR_W-1:0] last_v_q, last_v_d;

  always_comb begin
    col_d    = col_q;
    xin_d    = xin_q;
    row_d    = row_q;
    yin_d    = yin_q;
    last_v_d = last_v_q;
    if (valid_in) begin
      last_v_d = v_addr;
      if (h_addr == '0) begin
        col_d = '0;
        xin_d = '0;
        if (v_addr == '0) begin
          row_d = '0;
          yin_d = '0;
        end else if (v_addr != last_v_q) begin
          if (yin_q == YIN_W'(GLYPH_H - 1)) begin
            yin_d = '0;
            row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
          end else begin
            yin_d = yin_q + YIN_W'(1);
          end
        end
      end else if (xin_q == XIN_W'(GLYPH_W - 1)) begin
        xin_d = '0;
        col_d = col_q + HADDR_W'(1);
      end else begin
        xin_d = xin_q + XIN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      col_q    <= '0;
      xin_q    <= '0;
      row_q    <= '0;
      yin_q    <= '0;
      last_v_q <= '0;
    end else begin
      col_q    <= col_d;
      xin_q    <= xin_d;
      row_q    <= row_d;
      yin_q    <= yin_d;
      last_v_q <= last_v_d;
    end
  end

  assign col_next = col_d;
  assign row_next = row_d;
  assign yin_next = yin_d;
  assign xin      = xin_q;
  assign yin      = yin_q;

endmodule

// File: rtl/text_pixel_pipe.sv
// Five-stage text-mode pixel generator: raster position -> char RAM -> font ROM -> colour.
// clk, clrn                  : pixel clock, async active-low reset
// h_addr, v_addr, valid_in   : raster position from the timing controller
// frame_start                : once-per-frame pulse; latches scroll_top and advances blink
// scroll_top                 : physical RAM row shown at screen row 0
// cursor_en/row/col          : blinking underline cursor
// color_text/background      : foreground / background colours
// cram_addr/cram_data        : character RAM port (1-cycle read latency)
// font_addr/font_data        : font ROM port (1-cycle read latency)
// pix_color, pix_valid       : output pixel, 5 cycles after valid_in
module text_pixel_pipe
  import text_video_pkg::*;
#(
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned GLYPH_W    = DEF_GLYPH_W,
  parameter int unsigned GLYPH_H    = DEF_GLYPH_H,
  parameter int unsigned COLOR_W    = DEF_COLOR_W,
  parameter int unsigned BLINK_LOG2 = DEF_BLINK_LOG2
) (
  input  logic                            clk,
  input  logic                            clrn,
  input  logic [HADDR_W-1:0]              h_addr,
  input  logic [HADDR_W-1:0]              v_addr,
  input  logic                            valid_in,
  input  logic                            frame_start,
  input  logic [$clog2(ROWS)-1:0]         scroll_top,
  input  logic                            cursor_en,
  input  logic [$clog2(ROWS)-1:0]         cursor_row,
  input  logic [$clog2(COLS)-1:0]         cursor_col,
  input  logic [COLOR_W-1:0]              color_text,
  input  logic [COLOR_W-1:0]              color_background,
  output logic [$clog2(ROWS*COLS)-1:0]    cram_addr,
  input  logic [7:0]                      cram_data,
  output logic [$clog2(256*GLYPH_H)-1:0]  font_addr,
  input  logic [GLYPH_W-1:0]              font_data,
  output logic [COLOR_W-1:0]              pix_color,
  output logic                            pix_valid
);

  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned CRAM_AW = $clog2(ROWS * COLS);
  localparam int unsigned FONT_AW = $clog2(256 * GLYPH_H);
  localparam int unsigned XIN_W   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned YIN_W   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int unsigned FCNT_W  = BLINK_LOG2 + 1;

  logic [HADDR_W-1:0] col_next;
  logic [ROW_W-1:0]   row_next;
  logic [YIN_W-1:0]   yin_next;
  logic [XIN_W-1:0]   xin1;
  logic [YIN_W-1:0]   yin1;

  text_cell_counter #(
    .ROWS    (ROWS),
    .GLYPH_W (GLYPH_W),
    .GLYPH_H (GLYPH_H),
    .ROW_W   (ROW_W),
    .XIN_W   (XIN_W),
    .YIN_W   (YIN_W)
  ) u_cell_counter (
    .clk      (clk),
    .clrn     (clrn),
    .valid_in (valid_in),
    .h_addr   (h_addr),
    .v_addr   (v_addr),
    .col_next (col_next),
    .row_next (row_next),
    .yin_next (yin_next),
    .xin      (xin1),
    .yin      (yin1)
  );

  // Frame-synchronous state: only frame_start may change what the screen shows.
  logic [ROW_W-1:0]  scroll_q;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic              blink;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      scroll_q    <= '0;
      frame_cnt_q <= '0;
    end else if (frame_start) begin
      scroll_q    <= scroll_top;
      frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
    end
  end

  assign blink = frame_cnt_q[BLINK_LOG2];

  // E1 combinational: physical row, RAM address, out-of-grid and cursor flags.
  logic [ROW_W:0]     row_sum;
  logic [ROW_W-1:0]   phys_row;
  logic               oob_d;
  logic               hit_d;
  logic [CRAM_AW-1:0] cram_addr_d;

  always_comb begin
    row_sum  = {1'b0, row_next} + {1'b0, scroll_q};
    // Both operands are < ROWS, so one conditional subtract replaces the modulo.
    phys_row = (row_sum >= (ROW_W + 1)'(ROWS)) ? ROW_W'(row_sum - (ROW_W + 1)'(ROWS))
                                                : ROW_W'(row_sum);
    oob_d       = (col_next >= HADDR_W'(COLS));
    cram_addr_d = oob_d ? '0 : CRAM_AW'(32'(phys_row) * COLS + 32'(col_next));
    hit_d       = cursor_en & blink & (row_next == cursor_row)
                & (col_next == HADDR_W'(cursor_col))
                & (yin_next >= YIN_W'(GLYPH_H - 2));
  end

  // Sideband pipeline aligned with the memory round trips.
  logic             v1, v2, v3, v4;
  logic             oob1, oob2, oob3, oob4;
  logic             hit1, hit2, hit3, hit4;
  logic [XIN_W-1:0] xin2, xin3, xin4;
  logic [YIN_W-1:0] yin2;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cram_addr <= '0;
      font_addr <= '0;
      {v1, v2, v3, v4}         <= '0;
      {oob1, oob2, oob3, oob4} <= '0;
      {hit1, hit2, hit3, hit4} <= '0;
      xin2 <= '0;
      xin3 <= '0;
      xin4 <= '0;
      yin2 <= '0;
    end else begin
      // E1
      cram_addr <= cram_addr_d;
      v1        <= valid_in;
      oob1      <= oob_d;
      hit1      <= hit_d;
      // E2: RAM read in flight
      v2   <= v1;
      oob2 <= oob1;
      hit2 <= hit1;
      xin2 <= xin1;
      yin2 <= yin1;
      // E3
      font_addr <= FONT_AW'(font_index(cram_data, 32'(yin2), GLYPH_H));
      v3   <= v2;
      oob3 <= oob2;
      hit3 <= hit2;
      xin3 <= xin2;
      // E4: ROM read in flight
      v4   <= v3;
      oob4 <= oob3;
      hit4 <= hit3;
      xin4 <= xin3;
    end
  end

  // E5: bit select and colour.
  logic [GLYPH_W-1:0] glyph_row;
  logic               pix_on;
  logic [COLOR_W-1:0] color_d;

  always_comb begin
    glyph_row = font_data >> xin4;
    pix_on    = glyph_row[0] ^ hit4;
    if (!v4) begin
      color_d = '0;
    end else if (oob4 || !pix_on) begin
      color_d = color_background;
    end else begin
      color_d = color_text;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pix_color <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_color <= color_d;
      pix_valid <= v4;
    end
  end

endmodule
